// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the decoder_scan block: the mode encoding presented
// on the mode input, the FSM state encoding, and the legal range of the
// select width parameter.
package decoder_pkg;

  // Encoding of the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PULSE  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DIRECT     = 3'd1,
    ST_PULSE_WAIT = 3'd2,
    ST_PULSE_FIRE = 3'd3,
    ST_SCAN       = 3'd4
  } state_e;

  // Legal range of SEL_W (output width is 2**SEL_W).
  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 8;

endpackage

// File: rtl/decoder_scan_if.sv
// decoder_scan_if
// Bundles the control inputs, the sel handshake and the decoded output bus of
// decoder_scan.
//   master : drives en, mode, sel_valid, sel, dwell; observes the rest
//   slave  : the decoder_scan side
// Signals:
//   en        global enable
//   mode      operating mode (see decoder_pkg::mode_e)
//   sel_valid sel offered this cycle
//   sel       binary index to decode
//   sel_ready sel accepted this cycle when high together with sel_valid
//   dwell     SCAN: cycles per index minus 1
//   out       registered one-hot output, or all-zero
//   out_idx   binary index of the asserted out bit, 0 when out is zero
//   out_valid high exactly when out is non-zero
//   wrap      one-cycle pulse when SCAN wraps back to index 0
interface decoder_scan_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
);
  localparam int N = 1 << SEL_W;

  logic               en;
  logic [1:0]         mode;
  logic               sel_valid;
  logic [SEL_W-1:0]   sel;
  logic               sel_ready;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       out;
  logic [SEL_W-1:0]   out_idx;
  logic               out_valid;
  logic               wrap;

  modport master (
    output en, mode, sel_valid, sel, dwell,
    input  sel_ready, out, out_idx, out_valid, wrap
  );

  modport slave (
    input  en, mode, sel_valid, sel, dwell,
    output sel_ready, out, out_idx, out_valid, wrap
  );
endinterface

// File: rtl/decoder_n.sv
// decoder_n
// Combinational binary-to-one-hot decoder.
// Ports:
//   idx    : binary index, SEL_W bits
//   onehot : 2**SEL_W bits, exactly bit idx set
module decoder_n #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan
// Registered binary-to-one-hot decoder with three operating modes:
//   DIRECT : every accepted sel is decoded and held until the next one
//   PULSE  : an accepted sel is decoded for exactly one cycle
//   SCAN   : the output walks indices 0..N-1, each held dwell+1 cycles
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : decoder_scan_if slave (controls, sel handshake, decoded output)
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);

  localparam int N = 1 << SEL_W;

  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_sel_w_check
    $error("decoder_scan: SEL_W outside legal range");
  end

  state_e             st;
  mode_e              mode_q;   // mode latched on entry to the current state
  logic [DWELL_W-1:0] cnt;      // cycles left on the current SCAN index
  logic [SEL_W-1:0]   dec_in;
  logic [N-1:0]       dec_out;
  mode_e              mode_in;
  logic               leave;
  logic               xfer;

  assign mode_in = mode_e'(bus.mode);
  assign leave   = !bus.en || (mode_in != mode_q);
  assign xfer    = bus.sel_valid && bus.sel_ready;

  // One shared decoder: IDLE feeds index 0 (the first SCAN index), SCAN feeds
  // the next index, DIRECT/PULSE feed the offered sel.
  always_comb begin
    dec_in = bus.sel;
    if (st == ST_IDLE) begin
      dec_in = '0;
    end else if (st == ST_SCAN) begin
      dec_in = bus.out_idx + SEL_W'(1);
    end
  end

  decoder_n #(.SEL_W(SEL_W)) u_dec (
    .idx    (dec_in),
    .onehot (dec_out)
  );

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous; it is just the highest-priority branch
    // inside the clocked block, sampled on the rising edge.
    if (!rst_n) begin
      st            <= ST_IDLE;
      mode_q        <= MODE_DIRECT;
      cnt           <= '0;
      bus.out       <= '0;
      bus.out_idx   <= '0;
      bus.out_valid <= 1'b0;
      bus.wrap      <= 1'b0;
      bus.sel_ready <= 1'b0;
    end else begin
      bus.wrap <= 1'b0;
      if (st == ST_IDLE) begin
        // Outputs are already cleared on the way into IDLE.
        if (bus.en && (mode_in != MODE_RSVD)) begin
          mode_q <= mode_in;
          case (mode_in)
            MODE_DIRECT: begin
              st            <= ST_DIRECT;
              bus.sel_ready <= 1'b1;
            end
            MODE_PULSE: begin
              st            <= ST_PULSE_WAIT;
              bus.sel_ready <= 1'b1;
            end
            default: begin
              // SCAN shows index 0 on its very first cycle.
              st            <= ST_SCAN;
              bus.out       <= dec_out;
              bus.out_idx   <= dec_in;
              bus.out_valid <= 1'b1;
              cnt           <= bus.dwell;
            end
          endcase
        end
      end else if (leave) begin
        // Enable dropped or mode changed: drop everything and re-enter via IDLE.
        st            <= ST_IDLE;
        cnt           <= '0;
        bus.out       <= '0;
        bus.out_idx   <= '0;
        bus.out_valid <= 1'b0;
        bus.sel_ready <= 1'b0;
      end else begin
        case (st)
          ST_DIRECT: begin
            if (xfer) begin
              bus.out       <= dec_out;
              bus.out_idx   <= dec_in;
              bus.out_valid <= 1'b1;
            end
          end
          ST_PULSE_WAIT: begin
            if (xfer) begin
              st            <= ST_PULSE_FIRE;
              bus.out       <= dec_out;
              bus.out_idx   <= dec_in;
              bus.out_valid <= 1'b1;
              bus.sel_ready <= 1'b0;
            end
          end
          ST_PULSE_FIRE: begin
            st            <= ST_PULSE_WAIT;
            bus.out       <= '0;
            bus.out_idx   <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_ready <= 1'b1;
          end
          ST_SCAN: begin
            if (cnt == '0) begin
              // Load the next index; its dwell is sampled now, so a dwell
              // change only affects indices loaded after it.
              bus.out       <= dec_out;
              bus.out_idx   <= dec_in;
              bus.out_valid <= 1'b1;
              cnt           <= bus.dwell;
              bus.wrap      <= (dec_in == '0);
            end else begin
              cnt <= cnt - DWELL_W'(1);
            end
          end
          default: begin
            st            <= ST_IDLE;
            cnt           <= '0;
            bus.out       <= '0;
            bus.out_idx   <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
